// File: rtl/c4e_pcmplay_pkg.sv
// Shared definitions for the boot-copy engine: FSM encoding, SPI read command, helpers.
package c4e_pcmplay_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StData,
    StWrite,
    StDone
  } state_e;

  localparam logic [7:0] ReadOpcode = 8'h03;
  localparam int unsigned CmdBits = 32;

  // Flash bytes arrive b0 first, so the shift register holds {b0,b1,b2,b3}
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/c4e_pcmplay_spi_shifter.sv
// 32-bit SPI mode-0 shift engine: SCK divider, start/done handshake, tx/rx shift registers.
module c4e_pcmplay_spi_shifter
  import c4e_pcmplay_pkg::*;
#(
  parameter int unsigned SCK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] tx_data,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic [31:0] rx_data,
  output logic        done
);

  localparam logic [15:0] DivLast = 16'(SCK_DIV - 1);
  localparam logic [5:0]  BitLast = 6'(CmdBits - 1);

  logic        active_q;
  logic        sck_q;
  logic        done_q;
  logic [15:0] div_q;
  logic [5:0]  bit_q;
  logic [31:0] tx_q;
  logic [31:0] rx_q;

  // Divider and shifting: sample MISO on the rising SCK edge, advance MOSI on the falling edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      done_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (!active_q) begin
        if (start) begin
          active_q <= 1'b1;
          tx_q     <= tx_data;
          div_q    <= '0;
          bit_q    <= '0;
          sck_q    <= 1'b0;
        end
      end else if (div_q != DivLast) begin
        div_q <= div_q + 16'd1;
      end else begin
        div_q <= '0;
        if (!sck_q) begin
          sck_q <= 1'b1;
          rx_q  <= {rx_q[30:0], miso};
        end else begin
          sck_q <= 1'b0;
          tx_q  <= {tx_q[30:0], 1'b0};
          bit_q <= bit_q + 6'd1;
          if (bit_q == BitLast) begin
            active_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
      end
    end
  end

  assign sck     = sck_q;
  assign mosi    = tx_q[31];
  assign rx_data = rx_q;
  assign done    = done_q;

endmodule

// File: rtl/c4e_pcmplay_core_bootcopy.sv
// Boot copier: streams WORDS words from SPI flash into boot RAM over Avalon-MM,
// holding the CPU in reset until the copy completes.
module c4e_pcmplay_core_bootcopy
  import c4e_pcmplay_pkg::*;
#(
  parameter logic [23:0] FLASH_OFFSET = 24'h100000,
  parameter int unsigned WORDS        = 4096,
  parameter int unsigned SCK_DIV      = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        restart,
  output logic        spi_ncs,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [11:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  output logic        cpu_reset_req,
  output logic        busy,
  output logic        done
);

  localparam logic [11:0] AddrLast = 12'(WORDS - 1);

  state_e      state_q, state_d;
  logic        auto_q;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        sh_start;
  logic [31:0] sh_tx;
  logic        sh_done;
  logic [31:0] sh_rx;

  c4e_pcmplay_spi_shifter #(
    .SCK_DIV (SCK_DIV)
  ) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (sh_start),
    .tx_data (sh_tx),
    .miso    (spi_miso),
    .sck     (spi_sck),
    .mosi    (spi_mosi),
    .rx_data (sh_rx),
    .done    (sh_done)
  );

  // State, address and write-data registers; auto_q kicks off one copy after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      auto_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      auto_q  <= 1'b0;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic; the flash stream stays open across words, so DATA just restarts the shifter
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    sh_start = 1'b0;
    sh_tx    = '0;
    case (state_q)
      StIdle, StDone: begin
        if (auto_q || restart) begin
          state_d  = StCmd;
          addr_d   = '0;
          sh_start = 1'b1;
          sh_tx    = {ReadOpcode, FLASH_OFFSET};
        end
      end
      StCmd: begin
        if (sh_done) begin
          state_d  = StData;
          sh_start = 1'b1;
        end
      end
      StData: begin
        if (sh_done) begin
          state_d = StWrite;
          wdata_d = byte_swap(sh_rx);
        end
      end
      StWrite: begin
        if (!avm_waitrequest) begin
          if (addr_q == AddrLast) begin
            state_d = StDone;
          end else begin
            state_d  = StData;
            addr_d   = addr_q + 12'd1;
            sh_start = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status and bus outputs decoded straight from state so reset takes effect asynchronously
  always_comb begin
    busy           = (state_q == StCmd) || (state_q == StData) || (state_q == StWrite);
    spi_ncs        = !busy;
    avm_write      = (state_q == StWrite);
    avm_byteenable = avm_write ? 4'hF : 4'h0;
    avm_address    = addr_q;
    avm_writedata  = wdata_q;
    cpu_reset_req  = (state_q != StDone);
    done           = (state_q == StDone);
  end

endmodule

// File: tb/tb_c4e_pcmplay_core_bootcopy.sv
// Bench: two copiers against behavioural SPI flash models and an Avalon write scoreboard.
module tb_c4e_pcmplay_core_bootcopy;

  localparam int Words  = 64;
  localparam int Div    = 2;
  localparam int Period = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, restart, miso, waitreq;
  logic        ncs, sck, mosi, avm_write, cpu_rst, busy, done;
  logic [11:0] avm_address;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic        restart2, miso2, waitreq2;
  logic        ncs2, sck2, mosi2, write2, cpu2, busy2, done2;
  logic [11:0] addr2;
  logic [31:0] wdata2;
  logic [3:0]  be2;

  c4e_pcmplay_core_bootcopy #(
    .FLASH_OFFSET (24'h100000),
    .WORDS        (Words),
    .SCK_DIV      (Div)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .restart         (restart),
    .spi_ncs         (ncs),
    .spi_sck         (sck),
    .spi_mosi        (mosi),
    .spi_miso        (miso),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (wdata),
    .avm_byteenable  (be),
    .avm_waitrequest (waitreq),
    .cpu_reset_req   (cpu_rst),
    .busy            (busy),
    .done            (done)
  );

  c4e_pcmplay_core_bootcopy #(
    .FLASH_OFFSET (24'h100000),
    .WORDS        (1),
    .SCK_DIV      (1)
  ) dut2 (
    .clk             (clk),
    .reset_n         (reset_n),
    .restart         (restart2),
    .spi_ncs         (ncs2),
    .spi_sck         (sck2),
    .spi_mosi        (mosi2),
    .spi_miso        (miso2),
    .avm_address     (addr2),
    .avm_write       (write2),
    .avm_writedata   (wdata2),
    .avm_byteenable  (be2),
    .avm_waitrequest (waitreq2),
    .cpu_reset_req   (cpu2),
    .busy            (busy2),
    .done            (done2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] flash  [Words*4];
  logic [7:0] flash2 [4];

  function automatic logic [31:0] exp_word(input int w);
    return {flash[4*w+3], flash[4*w+2], flash[4*w+1], flash[4*w]};
  endfunction

  // Flash model for dut: collect the command, then stream bytes changing on SCK falling edges
  int  n_cmd = 0;
  int  sck_rises = 0;
  initial begin
    logic        p_ncs, p_sck;
    logic [31:0] cmd;
    int          cnt, k;
    time         t0;
    p_ncs = 1'b1; p_sck = 1'b0; cnt = 0; cmd = '0; t0 = 0;
    miso = 1'b0;
    forever begin
      @(ncs or sck);
      if (p_ncs === 1'b1 && ncs === 1'b0) begin
        cnt = 0;
        n_cmd++;
      end
      if (p_sck === 1'b0 && sck === 1'b1 && ncs === 1'b0) begin
        sck_rises++;
        if (cnt < 32) cmd = {cmd[30:0], mosi};
        if (cnt == 0) t0 = $time;
        if (cnt == 1) check_eq("sck_period", 64'($time - t0), 64'(2 * Div * Period));
        cnt++;
        if (cnt == 32) check_eq("cmd_bits", 64'(cmd), 64'h03100000);
      end
      if (p_sck === 1'b1 && sck === 1'b0 && ncs === 1'b0 && cnt >= 32) begin
        k = cnt - 32;
        if (k / 8 < Words * 4) miso = flash[k/8][7-(k%8)];
      end
      p_ncs = ncs;
      p_sck = sck;
    end
  end

  // Flash model for dut2 (single word, SCK_DIV=1)
  int rises2 = 0;
  initial begin
    logic        p_ncs, p_sck;
    logic [31:0] cmd;
    int          cnt, k;
    time         t0;
    p_ncs = 1'b1; p_sck = 1'b0; cnt = 0; cmd = '0; t0 = 0;
    miso2 = 1'b0;
    forever begin
      @(ncs2 or sck2);
      if (p_ncs === 1'b1 && ncs2 === 1'b0) begin
        cnt = 0;
        rises2 = 0;
      end
      if (p_sck === 1'b0 && sck2 === 1'b1 && ncs2 === 1'b0) begin
        rises2++;
        if (cnt < 32) cmd = {cmd[30:0], mosi2};
        if (cnt == 0) t0 = $time;
        if (cnt == 1) check_eq("sck_period2", 64'($time - t0), 64'(2 * Period));
        cnt++;
        if (cnt == 32) check_eq("cmd_bits2", 64'(cmd), 64'h03100000);
      end
      if (p_sck === 1'b1 && sck2 === 1'b0 && ncs2 === 1'b0 && cnt >= 32) begin
        k = cnt - 32;
        if (k / 8 < 4) miso2 = flash2[k/8][7-(k%8)];
      end
      p_ncs = ncs2;
      p_sck = sck2;
    end
  end

  // Scoreboard for dut: every accepted write must be the next word in flash order
  int copy_writes = 0;
  int acc7 = 0;
  initial begin
    logic p_ncs;
    int   exp_idx;
    p_ncs = 1'b1; exp_idx = 0;
    forever begin
      @(negedge clk);
      if (p_ncs === 1'b1 && ncs === 1'b0) begin
        exp_idx = 0;
        copy_writes = 0;
        acc7 = 0;
      end
      p_ncs = ncs;
      if (avm_write === 1'b1 && waitreq === 1'b0) begin
        if (exp_idx >= Words) begin
          check_eq("extra_write", 64'(avm_address), 64'hFFFF);
        end else begin
          check_eq("write", {20'd0, avm_address, be, wdata},
                   {20'd0, 12'(exp_idx), 4'hF, exp_word(exp_idx)});
          if (exp_idx == 0) check_eq("first_write", 64'(wdata), 64'h33221100);
        end
        if (avm_address == 12'd7) acc7++;
        exp_idx++;
        copy_writes++;
      end
    end
  end

  // Scoreboard for dut2
  int writes2 = 0;
  initial begin
    logic p_ncs;
    p_ncs = 1'b1;
    forever begin
      @(negedge clk);
      if (p_ncs === 1'b1 && ncs2 === 1'b0) writes2 = 0;
      p_ncs = ncs2;
      if (write2 === 1'b1) begin
        writes2++;
        check_eq("write2", {28'd0, addr2, be2, wdata2},
                 {28'd0, 12'd0, 4'hF, flash2[3], flash2[2], flash2[1], flash2[0]});
      end
    end
  end

  // Waitrequest driver: random stalls, plus one 5-cycle stall on word 7 when enabled
  logic stall7_en = 1'b0;
  logic rand_en = 1'b0;
  logic stall7_seen = 1'b0;
  initial begin
    logic [31:0] saved;
    int          r0;
    waitreq = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall7_en && !stall7_seen && avm_write && avm_address == 12'd7) begin
        stall7_seen = 1'b1;
        waitreq = 1'b1;
        saved = wdata;
        r0 = sck_rises;
        repeat (5) begin
          @(posedge clk);
          #1;
          check_eq("stall_hold", {19'd0, avm_write, avm_address, wdata},
                   {19'd0, 1'b1, 12'd7, saved});
        end
        check_eq("stall_sck", 64'(sck_rises - r0), 64'd0);
        waitreq = 1'b0;
      end else begin
        waitreq = rand_en && ($urandom_range(0, 3) == 0);
      end
    end
  end

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    check_eq(tag, 64'(done), 64'd1);
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; restart = 1'b0; restart2 = 1'b0; waitreq2 = 1'b0;
    for (int i = 0; i < Words * 4; i++) flash[i] = 8'($urandom);
    flash[0] = 8'h00; flash[1] = 8'h11; flash[2] = 8'h22; flash[3] = 8'h33;
    for (int i = 0; i < 4; i++) flash2[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_spi", 64'({ncs, sck, mosi}), 64'b100);
    check_eq("rst_avm", {15'd0, avm_write, avm_address, wdata, be}, 64'd0);
    check_eq("rst_status", 64'({cpu_rst, busy, done}), 64'b100);

    // Default copy with random stalls and a long stall on word 7
    rand_en = 1'b1;
    stall7_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("start_auto", 64'({busy, ncs, cpu_rst, done}), 64'b1010);
    wait_done(20000, "copy1_done");
    check_eq("copy1_writes", 64'(copy_writes), 64'(Words));
    check_eq("copy1_status", 64'({cpu_rst, busy, ncs}), 64'b001);
    check_eq("stall7_once", 64'({stall7_seen, 8'(acc7)}), {55'd0, 1'b1, 8'd1});
    check_eq("copy1_cmds", 64'(n_cmd), 64'd1);
    check_eq("dut2_status", 64'({done2, cpu2, busy2}), 64'b100);
    check_eq("dut2_rises", 64'(rises2), 64'd64);
    check_eq("dut2_writes", 64'(writes2), 64'd1);
    stall7_en = 1'b0;

    // Restart from DONE, then a restart pulse while busy must be ignored
    pulse_restart();
    check_eq("restart_cmd", 64'({cpu_rst, done, busy, ncs}), 64'b1010);
    repeat (500) @(negedge clk);
    pulse_restart();
    check_eq("busy_restart", 64'({busy, done}), 64'b10);
    wait_done(20000, "copy2_done");
    check_eq("copy2_writes", 64'(copy_writes), 64'(Words));
    check_eq("copy2_cmds", 64'(n_cmd), 64'd2);

    // Reset in the middle of a copy aborts it; the next copy starts from word 0
    pulse_restart();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(avm_write && avm_address == 12'd40) && n < 20000);
    check_eq("reach_word40", 64'(avm_address), 64'd40);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("abort_ncs", 64'({ncs, busy, cpu_rst, be}), {58'd0, 1'b1, 1'b0, 1'b1, 4'h0});
    @(negedge clk);
    reset_n = 1'b1;
    wait_done(20000, "copy4_done");
    check_eq("copy4_writes", 64'(copy_writes), 64'(Words));
    check_eq("copy4_cmds", 64'(n_cmd), 64'd4);
    check_eq("dut2_rerun", 64'({done2, 8'(writes2)}), {55'd0, 1'b1, 8'd1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
